// File: rtl/mux_bank_pipe.sv
// Pipelined NSRC-way group selector with registered valid/ready output and an auto-advancing select.
// Optional MUX_BANK_PIPE_SKID_EN adds a skid slot so in_ready comes straight from a register.
module mux_bank_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 3,
  parameter int NSRC  = 2,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NSRC*NCH*WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SELW-1:0]             sel,
  input  logic                        sel_load,
  input  logic                        auto_en,
  output logic [NCH*WIDTH-1:0]        out_data,
  output logic [SELW-1:0]             out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err
);

  localparam int              GW      = NCH * WIDTH;
  localparam bit              POW2    = (NSRC == (1 << SELW));
  localparam logic [SELW:0]   NSRC_W  = (SELW+1)'(NSRC);
  localparam logic [SELW-1:0] SEL_MAX = SELW'(NSRC - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   data_q, data_d;
  logic [SELW-1:0] osel_q, osel_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            sel_err_q, sel_err_d;
  logic [GW-1:0]   grp_s;
  logic            accept_s;
  logic            in_ready_s;
  logic            sel_oor_s;

  // Out-of-range loads only exist when NSRC is not a power of two.
  assign sel_oor_s = POW2 ? 1'b0 : ({1'b0, sel} >= NSRC_W);
  assign accept_s  = in_valid && in_ready_s;

  // Group mux driven by the current (pre-update) select register.
  always_comb begin
    grp_s = '0;
    for (int s = 0; s < NSRC; s++) begin
      grp_s = (sel_q == SELW'(s)) ? in_data[s*GW +: GW] : grp_s;
    end
  end

  // Select register next state: load beats auto-advance.
  always_comb begin
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    if (sel_load) begin
      if (sel_oor_s) begin
        sel_d     = '0;
        sel_err_d = 1'b1;
      end else begin
        sel_d = sel;
      end
    end else if (auto_en && accept_s) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end else begin
      sel_d = sel_q;
    end
  end

  // Select register and sticky error flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
    end
  end

`ifdef MUX_BANK_PIPE_SKID_EN
  logic            skid_vld_q, skid_vld_d;
  logic [GW-1:0]   skid_data_q, skid_data_d;
  logic [SELW-1:0] skid_sel_q, skid_sel_d;
  logic            in_ready_q;

  assign in_ready_s = in_ready_q;

  // Output/skid next state; the skid slot only fills while the output is stalled.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    osel_d      = osel_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d = FULL;
          data_d  = grp_s;
          osel_d  = sel_q;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (skid_vld_q) begin
            data_d     = skid_data_q;
            osel_d     = skid_sel_q;
            skid_vld_d = 1'b0;
          end else if (accept_s) begin
            data_d = grp_s;
            osel_d = sel_q;
          end else begin
            state_d = EMPTY;
          end
        end else if (accept_s) begin
          skid_vld_d  = 1'b1;
          skid_data_d = grp_s;
          skid_sel_d  = sel_q;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Skid slot and registered ready.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= !skid_vld_d;
    end
  end
`else
  assign in_ready_s = (state_q == EMPTY) || out_ready;

  // Single output register next state; a pop with a same-cycle accept stays FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    osel_d  = osel_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d = FULL;
          data_d  = grp_s;
          osel_d  = sel_q;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_d = FULL;
          data_d  = grp_s;
          osel_d  = sel_q;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
`endif

  // Output stage registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      osel_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign out_valid = (state_q == FULL);
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_bank_pipe.sv
// Directed bench for mux_bank_pipe (base build, NSRC=3, NCH=3, WIDTH=32).
module tb_mux_bank_pipe;

  localparam int WIDTH = 32;
  localparam int NCH   = 3;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;

  logic                      Clk;
  logic                      Rst;
  logic [NSRC*NCH*WIDTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [SELW-1:0]           sel;
  logic                      sel_load;
  logic                      auto_en;
  logic [NCH*WIDTH-1:0]      out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;

  int vectors;
  int miscompares;

  localparam logic [95:0] G0 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
  localparam logic [95:0] G1 = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
  localparam logic [95:0] G2 = {32'h0000_0303, 32'h0000_0202, 32'h0000_0101};
  localparam logic [95:0] GX = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};

  mux_bank_pipe #(.WIDTH(WIDTH), .NCH(NCH), .NSRC(NSRC)) dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sel_load(sel_load), .auto_en(auto_en), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b0;
    in_data     = {G2, G1, G0};
    in_valid    = 1'b0;
    sel         = 2'd0;
    sel_load    = 1'b0;
    auto_en     = 1'b0;
    out_ready   = 1'b1;

    // Reset values
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 96'd0);
    check("rst_out_sel", out_sel, 2'd0);
    check("rst_sel_err", sel_err, 1'b0);
    #9 Rst = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // First accept uses sel_q=0
    in_valid = 1'b1;
    tick();
    check("first_valid", out_valid, 1'b1);
    check("first_sel", out_sel, 2'd0);
    check("first_data", out_data, G0);
    in_valid = 1'b0;
    tick();
    check("first_drain", out_valid, 1'b0);

    // Basic select: load 1 then accept
    sel = 2'd1; sel_load = 1'b1;
    tick();
    sel_load = 1'b0; in_valid = 1'b1;
    tick();
    check("basic_data", out_data, G1);
    check("basic_sel", out_sel, 2'd1);
    check("basic_valid", out_valid, 1'b1);
    in_valid = 1'b0;

    // Auto sweep 0,1,2,0 back to back
    sel = 2'd0; sel_load = 1'b1;
    tick();
    sel_load = 1'b0; auto_en = 1'b1; in_valid = 1'b1;
    tick();
    check("sweep0_sel", out_sel, 2'd0);
    check("sweep0_rdy", in_ready, 1'b1);
    tick();
    check("sweep1_sel", out_sel, 2'd1);
    check("sweep1_valid", out_valid, 1'b1);
    tick();
    check("sweep2_sel", out_sel, 2'd2);
    check("sweep2_data", out_data, G2);
    tick();
    check("sweep3_sel", out_sel, 2'd0);
    check("sweep3_valid", out_valid, 1'b1);
    in_valid = 1'b0; auto_en = 1'b0;
    tick();
    check("sweep_drain", out_valid, 1'b0);

    // Backpressure: sel_q is now 1
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check("bp_sel", out_sel, 2'd1);
    in_data = {G2, GX, G0};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", out_data, G1);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_pop", out_valid, 1'b0);
    in_data = {G2, G1, G0};

    // Load beats auto-advance; accepted word uses old select
    sel = 2'd0; sel_load = 1'b1;
    tick();
    sel = 2'd2; auto_en = 1'b1; in_valid = 1'b1;
    tick();
    check("prio_old_sel", out_sel, 2'd0);
    check("prio_old_data", out_data, G0);
    sel_load = 1'b0;
    tick();
    check("prio_new_sel", out_sel, 2'd2);
    check("prio_new_data", out_data, G2);
    in_valid = 1'b0; auto_en = 1'b0;
    tick();

    // Out-of-range load
    sel = 2'd3; sel_load = 1'b1;
    tick();
    check("oor_err", sel_err, 1'b1);
    sel_load = 1'b0; in_valid = 1'b1;
    tick();
    check("oor_sel_zero", out_sel, 2'd0);
    in_valid = 1'b0; sel = 2'd2; sel_load = 1'b1;
    tick();
    check("oor_sticky", sel_err, 1'b1);
    sel_load = 1'b0; in_valid = 1'b1;
    tick();
    check("oor_valid_load", out_sel, 2'd2);
    check("oor_sticky2", sel_err, 1'b1);

    // Reset mid-stall
    out_ready = 1'b0;
    tick();
    check("stall_valid", out_valid, 1'b1);
    #2 Rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", out_data, 96'd0);
    check("async_rst_err", sel_err, 1'b0);
    check("async_rst_sel", out_sel, 2'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    #2 Rst = 1'b1;
    tick();
    check("rerst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    tick();
    check("rerst_sel", out_sel, 2'd0);
    check("rerst_data", out_data, G0);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
